// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared JK op codes, sequencer states and next-Q function
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    // Next Q of a JK flip-flop; shared by the sequencer mirror and flip-flop models.
    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic nq;
        case (jk)
            JK_HOLD:   nq = q;
            JK_RESET:  nq = 1'b0;
            JK_SET:    nq = 1'b1;
            default:   nq = ~q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// rtl/jk_cmd_fifo.sv - synchronous command FIFO with full/empty and head outputs
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// rtl/jk_cmd_seq.sv - buffered JK command sequencer with expected-Q mismatch flag
module jk_cmd_seq
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             J,
    output logic             K,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             err_clr
);

    localparam int W = 2 + CNT_W;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    seq_state_t       state;
    logic [1:0]       op_r;
    logic [CNT_W-1:0] cnt_r;
    logic             exp_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             last_cycle;
    logic [W-1:0]     head;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_len;

    assign head_op    = head[W-1 -: 2];
    assign head_len   = head[CNT_W-1:0];
    assign cmd_ready  = !fifo_full;
    assign last_cycle = (state == ST_RUN) && (cnt_r == '0);
    // Popping always means loading: from IDLE, or on the completing edge of RUN.
    assign pop        = !fifo_empty && ((state == ST_IDLE) || last_cycle);

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (cmd_valid),
        .wdata ({cmd_op, cmd_len}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
            op_r  <= JK_HOLD;
            cnt_r <= '0;
            J     <= 1'b0;
            K     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            exp_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            exp_q <= jk_next(exp_q, {J, K});
            if (q_fb != exp_q) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            done <= last_cycle;

            if (pop) begin
                state  <= ST_RUN;
                op_r   <= head_op;
                cnt_r  <= head_len;
                {J, K} <= head_op;
                busy   <= 1'b1;
            end else if (state == ST_RUN) begin
                if (cnt_r != '0) begin
                    cnt_r  <= cnt_r - CNT_ONE;
                    {J, K} <= op_r;
                end else begin
                    state  <= ST_IDLE;
                    {J, K} <= JK_HOLD;
                    busy   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/jk_cmd_seq.md
# jk_cmd_seq

Command sequencer that sits directly upstream of the JK flip-flop stage and drives its J/K inputs. Commands arrive over a valid/ready handshake. Each command is an operation plus a repeat length, and commands are buffered in a small FIFO. The block replays each operation onto J/K for a programmed number of cycles. It also mirrors the flip-flop's expected Q and flags any mismatch against Q fed back from the flip-flop.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- CNT_W, 4: width of the repeat-length field.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- n_rst  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals FIFO not full.
- cmd_op  in  2  operation, encoded as {J,K}: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- cmd_len  in  CNT_W  repeat length; the op is driven for cmd_len+1 cycles.
- J  out  1  registered J to the flip-flop.
- K  out  1  registered K to the flip-flop.
- q_fb  in  1  Q from the flip-flop.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky Q-mismatch flag.
- err_clr  in  1  clears err.

## Operation
- Accept: a command is written to the FIFO at any edge with cmd_valid && cmd_ready. Commands offered while full are not taken, and the source must hold them.
- FSM states are IDLE and RUN.
  - IDLE: J=K=0. If the FIFO is non-empty, pop the head, load op_r and cnt_r=cmd_len, drive J/K=op_r, and go to RUN.
  - RUN: hold J/K=op_r. Each edge with cnt_r≠0 decrements cnt_r.
  - When cnt_r==0 at an edge, the command completes and done is registered high for one cycle.
  - On completion, if the FIFO is non-empty, load the next command the same edge, with no bubble cycle. Otherwise go to IDLE and set J/K to 00.
- Push and pop on the same edge are both allowed, and the occupancy is unchanged.
- Expected-Q mirror exp_q updates every edge from the current J/K using the JK truth table: 00 holds, 01 gives 0, 10 gives 1, 11 inverts.
- Error check: at each edge, if q_fb≠exp_q, err is set. If err_clr is high and no mismatch occurs, err is cleared. A mismatch and err_clr on the same edge leave err set.
- FIFO wrap-around uses pointers of width log2(DEPTH)+1, so full and empty are distinguished by the MSB.

## Timing
- Reset values: J=0, K=0, busy=0, done=0, err=0, cmd_ready=1, exp_q=0, FIFO empty, state IDLE.
- Reset asserted mid-command aborts the command, flushes the FIFO and returns to the reset values immediately (asynchronously).
- Latency: a command accepted at edge e0 appears on J/K from edge e1. The flip-flop reflects it at e2, and the mismatch check covers it at e3.
- Each command occupies exactly cmd_len+1 consecutive cycles of J/K. Back-to-back commands are contiguous.
- done rises on the edge that ends the last J/K cycle of a command.
- cmd_ready falls on the edge that makes the FIFO full and rises on the edge of the first pop.

## Structure
- Shared package jk_pkg holds:
  - op constants JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11;
  - the FSM state encodings;
  - the function that computes the next Q from {J,K}, shared by this block's mirror and the flip-flop model.
- One sub-module, jk_cmd_fifo: a synchronous FIFO parameterised by DEPTH and width 2+CNT_W, with push, pop, full, empty and head outputs.

## Test plan
- Reset, then push one SET with len=0 → J=1,K=0 for exactly 1 cycle; done pulses; flip-flop Q=1; err=0.
- Push TOGGLE with len=3 paired with the flip-flop → 4 cycles of J=K=1; Q sequence 1,0,1,0 from Q=0; busy high for 4 cycles; a single done.
- Fill the FIFO with DEPTH commands while RUN is busy → cmd_ready=0 after the DEPTHth accept. Each later pop re-asserts cmd_ready. All commands execute in order, with no gaps between them.
- Force q_fb inverted for one cycle → err=1 on the next edge and it stays set. Assert err_clr with matching Q → err=0. Assert err_clr together with a mismatch → err stays 1.
- Assert n_rst low during a len=7 TOGGLE with 2 commands queued → J=K=0, busy=0, cmd_ready=1 and err=0 immediately. After release, no queued command executes.
- Push and pop on the same edge with 1 entry queued → occupancy stays at 1, and the push and pop both complete correctly.
